// File: rtl/alu_cmd_sequencer.sv
// Command feeder for the 4-bit signed ALU: buffers {opcode, a, b} in a small FIFO,
// presents the head to the ALU and captures Z with its opcode into a result register.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_opcode,
    input  logic [3:0]               cmd_a,
    input  logic [3:0]               cmd_b,
    output logic [2:0]               alu_opcode,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    input  logic [7:0]               alu_z,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_z,
    output logic [2:0]               res_opcode,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         op_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [2:0]    mem_op [DEPTH];
    logic [3:0]    mem_a  [DEPTH];
    logic [3:0]    mem_b  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          push;
    logic          issue;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // Both handshakes: a transfer happens on the rising edge where valid && ready are
    // both high; ready never depends on valid, and a full FIFO never bypasses to the ALU.
    assign cmd_ready = !full && !rst && !flush;
    assign push      = cmd_valid && cmd_ready;
    assign issue     = !empty && (!res_valid || res_ready) && !rst && !flush;

    assign alu_opcode = empty ? 3'b000 : mem_op[rd_ptr];
    assign alu_a      = empty ? 4'b0000 : mem_a[rd_ptr];
    assign alu_b      = empty ? 4'b0000 : mem_b[rd_ptr];

    assign fifo_level = level;

    // Payload storage needs no reset: entries are only visible through level/rd_ptr.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr] <= cmd_opcode;
            mem_a[wr_ptr]  <= cmd_a;
            mem_b[wr_ptr]  <= cmd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            res_valid  <= 1'b0;
            res_z      <= 8'h00;
            res_opcode <= 3'b000;
            op_count   <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            res_valid  <= 1'b0;
            res_z      <= 8'h00;
            res_opcode <= 3'b000;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr     <= rd_ptr + 1'b1;
                res_z      <= alu_z;
                res_opcode <= alu_opcode;
                res_valid  <= 1'b1;
                op_count   <= op_count + 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            case ({push, issue})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and randomized bench for alu_cmd_sequencer against a queue-based reference
// model, with a behavioural ALU closing the combinational alu_* -> alu_z loop.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [2:0]             cmd_opcode;
    logic [3:0]             cmd_a;
    logic [3:0]             cmd_b;
    logic [2:0]             alu_opcode;
    logic [3:0]             alu_a;
    logic [3:0]             alu_b;
    logic [7:0]             alu_z;
    logic                   res_valid;
    logic                   res_ready;
    logic [7:0]             res_z;
    logic [2:0]             res_opcode;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CNT_W-1:0]       op_count;

    int tests = 0;
    int fails = 0;

    // Reference model state: pending commands {op, a, b} and the result register.
    logic [10:0]      exp_q[$];
    logic             m_rv;
    logic [7:0]       m_rz;
    logic [2:0]       m_ro;
    logic [CNT_W-1:0] m_cnt;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_z      (alu_z),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_z      (res_z),
        .res_opcode (res_opcode),
        .fifo_level (fifo_level),
        .op_count   (op_count)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(logic [2:0] op, logic [3:0] a, logic [3:0] b);
        logic signed [7:0] ea;
        logic signed [7:0] eb;
        ea = {{4{a[3]}}, a};
        eb = {{4{b[3]}}, b};
        case (op)
            3'b101:  return ea + eb;
            3'b110:  return ea - eb;
            3'b111:  return ea * eb;
            default: return {a, b} ^ {5'b0, op};
        endcase
    endfunction

    always_comb alu_z = alu_ref(alu_opcode, alu_a, alu_b);

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        logic        exp_ready;
        logic        do_push;
        logic        do_issue;
        logic [10:0] head;
        logic [10:0] cmd;
        #1;
        head      = (exp_q.size() > 0) ? exp_q[0] : 11'd0;
        exp_ready = (exp_q.size() < DEPTH) && !rst && !flush;
        check("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_ready});
        check("alu_opcode", {29'd0, alu_opcode}, {29'd0, head[10:8]});
        check("alu_a", {28'd0, alu_a}, {28'd0, head[7:4]});
        check("alu_b", {28'd0, alu_b}, {28'd0, head[3:0]});
        do_push  = cmd_valid && exp_ready;
        do_issue = (exp_q.size() > 0) && (!m_rv || res_ready) && !rst && !flush;
        cmd      = {cmd_opcode, cmd_a, cmd_b};
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            m_rv  = 1'b0;
            m_rz  = 8'h00;
            m_ro  = 3'b000;
            m_cnt = '0;
        end else if (flush) begin
            exp_q.delete();
            m_rv = 1'b0;
            m_rz = 8'h00;
            m_ro = 3'b000;
        end else begin
            if (do_issue) begin
                head = exp_q.pop_front();
                m_rz = alu_ref(head[10:8], head[7:4], head[3:0]);
                m_ro = head[10:8];
                m_rv = 1'b1;
                m_cnt = m_cnt + 1'b1;
            end else if (m_rv && res_ready) begin
                m_rv = 1'b0;
            end
            if (do_push) exp_q.push_back(cmd);
        end
        check("res_valid", {31'd0, res_valid}, {31'd0, m_rv});
        check("res_z", {24'd0, res_z}, {24'd0, m_rz});
        check("res_opcode", {29'd0, res_opcode}, {29'd0, m_ro});
        check("fifo_level", {29'd0, fifo_level}, exp_q.size());
        check("op_count", {24'd0, op_count}, {24'd0, m_cnt});
        @(negedge clk);
    endtask

    // Driver task: apply one cycle of inputs, then run the checked cycle.
    task automatic drive(logic v, logic [2:0] op, logic [3:0] a, logic [3:0] b,
                         logic rr, logic fl, logic rs);
        cmd_valid  = v;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        res_ready  = rr;
        flush      = fl;
        rst        = rs;
        cycle();
    endtask

    task automatic drive_rand(logic v, logic rr);
        drive(v, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), rr, 1'b0, 1'b0);
    endtask

    initial begin
        m_rv = 1'b0; m_rz = 8'h00; m_ro = 3'b000; m_cnt = '0;
        rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_opcode = 3'b000; cmd_a = 4'h0; cmd_b = 4'h0;
        @(posedge clk);
        @(negedge clk);

        // Reset state
        drive(0, 3'b000, 4'h0, 4'h0, 0, 0, 1);
        drive(0, 3'b000, 4'h0, 4'h0, 0, 0, 1);

        // Single push, result one edge after the push edge
        drive(1, 3'b101, 4'b0110, 4'b1101, 1, 0, 0);
        drive(0, 3'b000, 4'h0, 4'h0, 0, 0, 0);
        check("first_z", {24'd0, res_z}, 32'h03);
        check("first_cnt", {24'd0, op_count}, 32'd1);
        drive(0, 3'b000, 4'h0, 4'h0, 1, 0, 0);

        // Backpressure: five commands, one in result register and four in the FIFO
        drive(1, 3'b111, 4'h6, 4'hD, 0, 0, 0);
        drive(1, 3'b110, 4'h1, 4'h3, 0, 0, 0);
        check("bp_first_z", {24'd0, res_z}, 32'hEE);
        drive(1, 3'b101, 4'h7, 4'h7, 0, 0, 0);
        drive(1, 3'b111, 4'h8, 4'h8, 0, 0, 0);
        drive(1, 3'b110, 4'h8, 4'h7, 0, 0, 0);
        check("bp_full_level", {29'd0, fifo_level}, 32'd4);
        drive(1, 3'b101, 4'h2, 4'h2, 0, 0, 0);
        drive(0, 3'b000, 4'h0, 4'h0, 1, 0, 0);
        check("bp_second_z", {24'd0, res_z}, 32'hFE);
        for (int i = 0; i < 5; i++) drive(0, 3'b000, 4'h0, 4'h0, 1, 0, 0);

        // Continuous push with res_ready high; op_count wraps
        for (int i = 0; i < 300; i++) drive_rand(1, 1);
        for (int i = 0; i < 2; i++) drive(0, 3'b000, 4'h0, 4'h0, 1, 0, 0);

        // Push and pop in the same cycle at level 2, across pointer wrap
        for (int i = 0; i < 3; i++) drive_rand(1, 0);
        for (int i = 0; i < 6; i++) drive_rand(1, 1);
        for (int i = 0; i < 4; i++) drive(0, 3'b000, 4'h0, 4'h0, 1, 0, 0);

        // Flush with FIFO=3 and a held result; push in the flush cycle is dropped
        for (int i = 0; i < 4; i++) drive_rand(1, 0);
        drive(1, 3'b101, 4'h1, 4'h1, 0, 1, 0);
        drive(0, 3'b000, 4'h0, 4'h0, 1, 0, 0);

        // Reset mid-stream with a held result
        for (int i = 0; i < 4; i++) drive_rand(1, 0);
        drive(1, 3'b101, 4'h1, 4'h1, 0, 0, 1);
        drive(0, 3'b000, 4'h0, 4'h0, 1, 0, 0);
        check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 149) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream feeder for the 4-bit signed ALU (A, B, OPCODE in; Z 8-bit out).
- Accepts {OPCODE, A, B} commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Presents the FIFO head to the ALU and captures the ALU's Z plus its opcode into a result register, with valid/ready toward the consumer.
- Counts issued operations; supports synchronous flush.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, ≥2.
- CNT_W, 8, width of the issued-operation counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset.
- flush  in  1  synchronous clear of FIFO and result register.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
- cmd_opcode  in  3  ALU opcode.
- cmd_a  in  4  operand A, signed.
- cmd_b  in  4  operand B, signed.
- alu_opcode  out  3  to ALU OPCODE.
- alu_a  out  4  to ALU A.
- alu_b  out  4  to ALU B.
- alu_z  in  8  from ALU Z; combinational function of alu_*.
- res_valid  out  1  result held.
- res_ready  in  1  consumer takes result.
- res_z  out  8  captured Z.
- res_opcode  out  3  opcode that produced res_z.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- op_count  out  CNT_W  issued operations, wraps.

Behaviour:
- Reset: one clock, synchronous, active-high (rst sampled on rising clk).
- While rst is high, the next edge sets FIFO empty, res_valid=0, res_z=0, res_opcode=0, op_count=0, fifo_level=0.
- cmd_ready = !full && !rst && !flush (combinational). No bypass when full.
- Push: cmd_valid && cmd_ready writes {opcode, a, b} at wr_ptr. wr_ptr wraps modulo DEPTH.
- alu_opcode/alu_a/alu_b = FIFO head when non-empty; 3'b000 / 4'b0 / 4'b0 when empty. All three are driven from registered storage only.
- Issue condition: !empty && (!res_valid || res_ready).
- On issue:
  - res_z <= alu_z, res_opcode <= head opcode, res_valid <= 1.
  - Pop head; rd_ptr wraps modulo DEPTH.
  - op_count <= op_count+1, wrapping at 2^CNT_W.
- No issue and res_ready && res_valid: res_valid <= 0. res_z and res_opcode hold their last value.
- Latency: push at edge N → on ALU pins after N → res_valid at edge N+1 (empty FIFO, idle result). Sustained throughput is 1 op/cycle with res_ready held high.
- Simultaneous push and pop: level unchanged. Allowed at any level < DEPTH, including level 0 only from cycle N+1.
- Full: level==DEPTH, cmd_ready=0, issue continues normally.
- Empty: no issue; res_valid drains normally.
- Backpressure: res_valid && !res_ready holds res_z, res_opcode and the FIFO head stable. The FIFO keeps filling until full.
- flush (rst has priority):
  - Empties FIFO, clears res_valid, res_z and res_opcode.
  - Pushes and issue in that cycle are suppressed.
  - op_count is kept.
- Reset or flush mid-stream: any in-flight result is discarded without handshake.
- ALU contract (for checking, not implemented here):
  - 101: Z = sext(A+B).
  - 110: Z = sext(A−B).
  - 111: Z = A*B as 8-bit two's complement.

Test Plan:
- Reset then single push op=101 A=0110 B=1101 → res_valid at next edge, res_z=8'h03, res_opcode=101, op_count=1.
- res_ready held low, push 5 commands with DEPTH=4 → 1 in result register, 4 in FIFO, cmd_ready=0, fifo_level=4. Then raise res_ready → results drain in order, one per cycle: 111 6*−3 → 8'hEE first, then 110 1−3 → 8'hFE, etc.
- Continuous push every cycle, res_ready=1 → fifo_level ≤1, op_count increments every cycle, wraps 255→0 after 256 ops.
- Push and pop in the same cycle at level 2 → fifo_level stays 2. Order preserved across wr_ptr/rd_ptr wrap.
- flush asserted with FIFO=3 and res_valid=1 → next cycle fifo_level=0, res_valid=0, res_z=0, op_count unchanged. Push in the flush cycle is dropped and cmd_ready=0 during flush.
- rst asserted mid-stream with res_valid=1, res_ready=0 → all outputs zero after the edge. cmd_ready=0 while rst is high and returns to 1 the cycle after release.
